// File: rtl/inert_seq_pkg.sv
// ---------------------------------------------------------------------------
// inert_pkg
// Shared definitions for the inertial sensor transaction sequencer:
//   - inert_state_t : sequencer FSM states
//   - inert_dbg_t   : debug view of the sequencer (state, command index,
//                     pending data-ready request)
//   - CMD_*         : command words sent to the SPI monarch
//   - CFG_LAST, RD_FIRST, RD_LAST : command index landmarks
//   - cmd_rom()     : command index -> command word lookup
// ---------------------------------------------------------------------------
package inert_pkg;

    typedef enum logic [2:0] {
        PWRUP  = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        IDLE   = 3'd3,
        UPDATE = 3'd4
    } inert_state_t;

    typedef struct packed {
        inert_state_t state;
        logic [3:0]   idx;
        logic         pending;
    } inert_dbg_t;

    // Configuration writes, issued once after power-up.
    localparam logic [15:0] CMD_CFG0  = 16'h0D02;
    localparam logic [15:0] CMD_CFG1  = 16'h1053;
    localparam logic [15:0] CMD_CFG2  = 16'h1150;

    // Rate register reads; the low byte of each command is don't-care.
    localparam logic [15:0] CMD_PTCH_L = 16'hA200;
    localparam logic [15:0] CMD_PTCH_H = 16'hA300;
    localparam logic [15:0] CMD_ROLL_L = 16'hA400;
    localparam logic [15:0] CMD_ROLL_H = 16'hA500;
    localparam logic [15:0] CMD_YAW_L  = 16'hA600;
    localparam logic [15:0] CMD_YAW_H  = 16'hA700;

    localparam logic [3:0] CFG_FIRST = 4'd0;
    localparam logic [3:0] CFG_LAST  = 4'd2;
    localparam logic [3:0] RD_FIRST  = 4'd3;
    localparam logic [3:0] RD_LAST   = 4'd8;

    function automatic logic [15:0] cmd_rom(input logic [3:0] idx);
        logic [15:0] cmd;
        case (idx)
            4'd0:    cmd = CMD_CFG0;
            4'd1:    cmd = CMD_CFG1;
            4'd2:    cmd = CMD_CFG2;
            4'd3:    cmd = CMD_PTCH_L;
            4'd4:    cmd = CMD_PTCH_H;
            4'd5:    cmd = CMD_ROLL_L;
            4'd6:    cmd = CMD_ROLL_H;
            4'd7:    cmd = CMD_YAW_L;
            4'd8:    cmd = CMD_YAW_H;
            default: cmd = 16'h0000;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/inert_seq_int_sync.sv
// ---------------------------------------------------------------------------
// int_sync
// Brings an asynchronous active-high request into the clk domain through a
// two-flop synchronizer and produces a one-cycle pulse on each rising edge
// of the synchronized level.
// Ports:
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset
//   i_async  : asynchronous input level
//   o_rise   : one-cycle pulse, synchronized rising edge of i_async
// ---------------------------------------------------------------------------
module int_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/inert_seq.sv
// ---------------------------------------------------------------------------
// inert_seq
// Transaction sequencer between the 16-bit SPI monarch and the rate
// consumer. After reset it waits 2^PWRUP_W-1 cycles for sensor power-up,
// issues three configuration writes, then answers every sensor data-ready
// interrupt with six register reads and presents the assembled pitch, roll
// and yaw rates together with a one-cycle vld strobe.
//
// Monarch handshake: wrt is a one-cycle start strobe; wt_data is held from
// wrt until done. done is a level that the monarch clears on the wrt edge,
// so a done still high during the wrt cycle belongs to the previous
// transaction and is ignored; the transaction completes on the first done=1
// seen in WAIT. rd_data[7:0] is valid whenever done=1.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   INT              : sensor data-ready, asynchronous, active high
//   done, rd_data    : monarch completion level and receive data
//   wrt, wt_data     : monarch start strobe and command word
//   ptch_rt, roll_rt, yaw_rt : assembled rates {high byte, low byte}
//   vld              : one-cycle strobe, all three rates updated together
//   cfg_done         : configuration finished, sticky until reset
//   o_dbg            : sequencer state, command index and pending flag
// ---------------------------------------------------------------------------
module inert_seq
    import inert_pkg::*;
#(
    parameter int PWRUP_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] wt_data,
    output logic [15:0] ptch_rt,
    output logic [15:0] roll_rt,
    output logic [15:0] yaw_rt,
    output logic        vld,
    output logic        cfg_done,
    output inert_dbg_t  o_dbg
);

    inert_state_t        r_state;
    inert_state_t        w_state_nxt;
    logic [3:0]          r_idx;
    logic [3:0]          w_idx_nxt;
    logic [PWRUP_W-1:0]  r_cnt;
    logic [PWRUP_W-1:0]  w_cnt_plus;
    logic                r_pend;
    logic                r_cfg_done;
    logic [15:0]         r_wt_data;
    logic [7:0]          r_p_lo;
    logic [7:0]          r_p_hi;
    logic [7:0]          r_r_lo;
    logic [7:0]          r_r_hi;
    logic [7:0]          r_y_lo;
    logic [7:0]          r_y_hi;
    logic [15:0]         r_ptch;
    logic [15:0]         r_roll;
    logic [15:0]         r_yaw;
    logic                r_vld;

    logic                w_int_rise;
    logic                w_cnt_inc;
    logic                w_cap;
    logic                w_cfg_set;
    logic                w_pend_clr;
    logic                w_upd;
    logic                w_wrt;
    logic                w_unused_rd_hi;

    // Only the low byte of each read response carries register data.
    assign w_unused_rd_hi = ^rd_data[15:8];

    int_sync u_int_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_async (INT),
        .o_rise  (w_int_rise)
    );

    assign w_cnt_plus = r_cnt + {{(PWRUP_W-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PWRUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_inc   = 1'b0;
        w_cap       = 1'b0;
        w_cfg_set   = 1'b0;
        w_pend_clr  = 1'b0;
        w_upd       = 1'b0;
        w_wrt       = 1'b0;
        case (r_state)
            PWRUP: begin
                // Leave on the edge where the counter becomes all-ones.
                w_cnt_inc = 1'b1;
                if (w_cnt_plus == {PWRUP_W{1'b1}}) begin
                    w_state_nxt = ISSUE;
                    w_idx_nxt   = CFG_FIRST;
                end
            end
            ISSUE: begin
                // done is deliberately not looked at here.
                w_wrt       = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (done) begin
                    if (r_idx < CFG_LAST) begin
                        w_idx_nxt   = r_idx + 4'd1;
                        w_state_nxt = ISSUE;
                    end else if (r_idx == CFG_LAST) begin
                        w_cfg_set   = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (r_idx < RD_LAST) begin
                        w_cap       = 1'b1;
                        w_idx_nxt   = r_idx + 4'd1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_cap       = 1'b1;
                        w_state_nxt = UPDATE;
                    end
                end
            end
            IDLE: begin
                if (r_pend) begin
                    w_pend_clr  = 1'b1;
                    w_idx_nxt   = RD_FIRST;
                    w_state_nxt = ISSUE;
                end
            end
            UPDATE: begin
                w_upd       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = PWRUP;
                w_idx_nxt   = CFG_FIRST;
            end
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= 4'd0;
            r_pend     <= 1'b0;
            r_cfg_done <= 1'b0;
            r_wt_data  <= 16'h0000;
        end else begin
            if (w_cnt_inc) begin
                r_cnt <= w_cnt_plus;
            end
            r_idx <= w_idx_nxt;
            // A new edge in the clearing cycle must survive: set wins.
            r_pend     <= w_int_rise | (r_pend & ~w_pend_clr);
            r_cfg_done <= r_cfg_done | w_cfg_set;
            // Command word is loaded as ISSUE is entered and then held
            // through WAIT until the monarch reports done.
            if (w_state_nxt == ISSUE) begin
                r_wt_data <= cmd_rom(w_idx_nxt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_lo <= 8'h00;
            r_p_hi <= 8'h00;
            r_r_lo <= 8'h00;
            r_r_hi <= 8'h00;
            r_y_lo <= 8'h00;
            r_y_hi <= 8'h00;
        end else if (w_cap) begin
            case (r_idx)
                4'd3:    r_p_lo <= rd_data[7:0];
                4'd4:    r_p_hi <= rd_data[7:0];
                4'd5:    r_r_lo <= rd_data[7:0];
                4'd6:    r_r_hi <= rd_data[7:0];
                4'd7:    r_y_lo <= rd_data[7:0];
                4'd8:    r_y_hi <= rd_data[7:0];
                default: ;
            endcase
        end
    end

    // All three rates load on one edge from the complete set of holding
    // bytes, and vld rises with them, so a consumer never sees a mix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptch <= 16'h0000;
            r_roll <= 16'h0000;
            r_yaw  <= 16'h0000;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= w_upd;
            if (w_upd) begin
                r_ptch <= {r_p_hi, r_p_lo};
                r_roll <= {r_r_hi, r_r_lo};
                r_yaw  <= {r_y_hi, r_y_lo};
            end
        end
    end

    assign wrt      = w_wrt;
    assign wt_data  = r_wt_data;
    assign ptch_rt  = r_ptch;
    assign roll_rt  = r_roll;
    assign yaw_rt   = r_yaw;
    assign vld      = r_vld;
    assign cfg_done = r_cfg_done;

    assign o_dbg.state   = r_state;
    assign o_dbg.idx     = r_idx;
    assign o_dbg.pending = r_pend;

endmodule

// File: tb/tb_inert_seq.sv
// ---------------------------------------------------------------------------
// tb_inert_seq
// Drives inert_seq with a behavioural SPI monarch and a sensor that returns
// random (or scripted) register bytes. Commands expected from the sequencer
// and rate triples expected at vld are queued by the scenarios and by the
// monarch model; monitors compare them against what the DUT presents.
// ---------------------------------------------------------------------------
module tb_inert_seq;
    import inert_pkg::*;

    localparam int PW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] wt_data;
    logic [15:0] ptch_rt;
    logic [15:0] roll_rt;
    logic [15:0] yaw_rt;
    logic        vld;
    logic        cfg_done;
    inert_dbg_t  o_dbg;

    inert_seq #(.PWRUP_W(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .INT      (INT),
        .done     (done),
        .rd_data  (rd_data),
        .wrt      (wrt),
        .wt_data  (wt_data),
        .ptch_rt  (ptch_rt),
        .roll_rt  (roll_rt),
        .yaw_rt   (yaw_rt),
        .vld      (vld),
        .cfg_done (cfg_done),
        .o_dbg    (o_dbg)
    );

    // ------------------------------------------------------ clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- scoreboard
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] cmd_q[$];
    logic [47:0] exp_q[$];
    int          vld_cnt = 0;
    int          wrt_cnt = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // --------------------------------------------------------- monarch model
    bit          m_busy = 1'b0;
    bit          m_wrt_seen = 1'b0;
    logic [15:0] m_cmd = 16'h0000;
    int          m_cnt = 0;
    int          lat_min = 1;
    int          lat_max = 4;
    bit          scripted = 1'b0;
    logic [7:0]  seq_b[6];

    task automatic monarch_respond();
        int         slot;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [31:0] r;
        r  = $urandom;
        hi = r[7:0];
        lo = r[15:8];
        m_busy = 1'b0;
        if (m_cmd[15]) begin
            slot = int'(m_cmd[11:8]) - 2;
            if (slot >= 0 && slot < 6) begin
                if (scripted) lo = 8'(8'h11 * (slot + 1));
                seq_b[slot] = lo;
                // Byte order pitchL, pitchH, rollL, rollH, yawL, yawH.
                if (slot == 5)
                    exp_q.push_back({seq_b[1], seq_b[0], seq_b[3], seq_b[2], seq_b[5], seq_b[4]});
            end
        end
        rd_data = {hi, lo};
        done    = 1'b1;
    endtask

    // done is cleared just after the wrt edge, so it is still high (stale)
    // while the sequencer sits in its wrt cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_busy     = 1'b0;
                m_wrt_seen = 1'b0;
                done       = 1'b0;
            end else if (m_wrt_seen) begin
                m_wrt_seen = 1'b0;
                done       = 1'b0;
                m_busy     = 1'b1;
                m_cnt      = $urandom_range(lat_max, lat_min);
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) monarch_respond();
            end
        end
    end

    // ------------------------------------------------------------- monitor
    bit          prev_vld = 1'b0;
    logic [47:0] last_rates = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_vld   = 1'b0;
                last_rates = {ptch_rt, roll_rt, yaw_rt};
                continue;
            end
            if (wrt) begin
                wrt_cnt++;
                check("wrt_while_busy", 48'(m_busy), 48'd0);
                if (cmd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wrt: got cmd %h expected none at %0t", wt_data, $time);
                end else begin
                    check("cmd", 48'(wt_data), 48'(cmd_q.pop_front()));
                end
                m_wrt_seen = 1'b1;
                m_cmd      = wt_data;
            end
            if (vld) begin
                vld_cnt++;
                check("vld_width", 48'(prev_vld), 48'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_vld: got rates %h expected none at %0t",
                             {ptch_rt, roll_rt, yaw_rt}, $time);
                end else begin
                    check("rates", {ptch_rt, roll_rt, yaw_rt}, exp_q.pop_front());
                end
            end else begin
                check("rates_stable", {ptch_rt, roll_rt, yaw_rt}, last_rates);
            end
            prev_vld   = vld;
            last_rates = {ptch_rt, roll_rt, yaw_rt};
        end
    end

    // --------------------------------------------------------- driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_cfg();
        cmd_q.push_back(16'h0D02);
        cmd_q.push_back(16'h1053);
        cmd_q.push_back(16'h1150);
    endtask

    task automatic push_reads();
        for (int i = 0; i < 6; i++) cmd_q.push_back(16'hA200 + 16'(i * 16'h0100));
    endtask

    task automatic pulse_int(input int hi_cyc, input int lo_cyc);
        #($urandom_range(8, 1));
        INT = 1'b1;
        repeat (hi_cyc) @(posedge clk);
        #($urandom_range(8, 1));
        INT = 1'b0;
        repeat (lo_cyc) @(posedge clk);
    endtask

    task automatic release_and_time_first_wrt(input string name);
        int k;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (!wrt && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({name, "_first_wrt_delay"}, 48'(k), 48'd15);
        check({name, "_first_cmd"}, 48'(wt_data), 48'h0D02);
        check({name, "_cfg_done_early"}, 48'(cfg_done), 48'd0);
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int k;
        k = 0;
        while (!(cmd_q.size() == 0 && o_dbg.state == IDLE && !m_busy && !o_dbg.pending)
               && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_timeout"}, 48'(k >= budget), 48'd0);
        tick(6);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_wrt"}, 48'(wrt), 48'd0);
        check({name, "_vld"}, 48'(vld), 48'd0);
        check({name, "_cfg_done"}, 48'(cfg_done), 48'd0);
        check({name, "_wt_data"}, 48'(wt_data), 48'd0);
        check({name, "_rates"}, {ptch_rt, roll_rt, yaw_rt}, 48'd0);
        check({name, "_state"}, 48'(o_dbg.state), 48'(PWRUP));
        check({name, "_pending"}, 48'(o_dbg.pending), 48'd0);
    endtask

    // ------------------------------------------------------------ scenarios
    initial begin
        int base_v;
        int base_w;
        int k;

        // Reset and configuration with INT held low.
        tick(3);
        check_reset_outputs("rst");
        push_cfg();
        base_w = wrt_cnt;
        release_and_time_first_wrt("cfg");
        wait_quiet("cfg", 300);
        check("cfg_done_set", 48'(cfg_done), 48'd1);
        tick(20);
        check("cfg_wrt_count", 48'(wrt_cnt - base_w), 48'd3);

        // One INT pulse, scripted bytes 11..66.
        scripted = 1'b1;
        base_v = vld_cnt;
        push_reads();
        pulse_int(3, 3);
        wait_quiet("seq1", 300);
        scripted = 1'b0;
        check("seq1_vld_count", 48'(vld_cnt - base_v), 48'd1);
        check("seq1_ptch", 48'(ptch_rt), 48'h2211);
        check("seq1_roll", 48'(roll_rt), 48'h4433);
        check("seq1_yaw", 48'(yaw_rt), 48'h6655);

        // Three INT pulses while a sequence is running: one more sequence.
        lat_min = 3;
        lat_max = 5;
        base_v = vld_cnt;
        base_w = wrt_cnt;
        push_reads();
        push_reads();
        pulse_int(3, 0);
        k = 0;
        while (wrt_cnt == base_w && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("merge_start_timeout", 48'(k >= 50), 48'd0);
        for (int i = 0; i < 3; i++) pulse_int(2, 2);
        wait_quiet("merge", 600);
        tick(20);
        check("merge_vld_count", 48'(vld_cnt - base_v), 48'd2);
        check("merge_pending", 48'(o_dbg.pending), 48'd0);
        check("merge_state", 48'(o_dbg.state), 48'(IDLE));
        lat_min = 1;
        lat_max = 4;

        // Randomized single sequences.
        for (int n = 0; n < 6; n++) begin
            base_v = vld_cnt;
            push_reads();
            tick($urandom_range(10, 1));
            pulse_int($urandom_range(4, 2), $urandom_range(4, 2));
            wait_quiet("rand", 300);
            check("rand_vld_count", 48'(vld_cnt - base_v), 48'd1);
        end

        // INT pulse during power-up is serviced right after configuration.
        @(negedge clk);
        rst_n = 1'b0;
        cmd_q.delete();
        exp_q.delete();
        tick(3);
        push_cfg();
        push_reads();
        base_v = vld_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        pulse_int(3, 3);
        wait_quiet("early", 400);
        check("early_cfg_done", 48'(cfg_done), 48'd1);
        check("early_vld_count", 48'(vld_cnt - base_v), 48'd1);

        // Reset during the fourth read's WAIT.
        push_reads();
        pulse_int(3, 3);
        k = 0;
        while (!(wrt && wt_data == 16'hA500) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("midrst_reach_timeout", 48'(k >= 200), 48'd0);
        @(posedge clk);
        #2;
        check("midrst_in_wait", 48'(o_dbg.state), 48'(WAIT));
        rst_n = 1'b0;
        done  = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cmd_q.delete();
        exp_q.delete();
        tick(3);
        push_cfg();
        release_and_time_first_wrt("rerun");
        wait_quiet("rerun", 300);
        check("rerun_cfg_done", 48'(cfg_done), 48'd1);
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
